// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, data and memory handshake bundle for unified_mem_arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_ack_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;
  logic              stall_o;
  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i, mem_ack_i,
    output if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
  );
  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i, mem_ack_i,
    input  if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between fetch and data requesters, data first.
// Define ARB_PERF_CNT_EN to add saturating per-requester wait-cycle counters.
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk_i,
  input logic start_i,
  unified_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] if_wait_cnt_o,
  output logic [31:0] dm_wait_cnt_o
`endif
);
  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_t;
  state_t r_state, w_next;
  logic r_dm_own, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_dm_rdata;
  logic w_acc, w_owner_req, w_grant, w_cap;
  assign w_acc       = (r_state == IF_ACC) || (r_state == DM_ACC);
  assign w_owner_req = r_dm_own ? bus.dm_req_i : bus.if_req_i;
  assign w_grant     = (r_state == IDLE) && (bus.dm_req_i || bus.if_req_i);
  // a requester that dropped its request before completion keeps its old read data
  assign w_cap       = w_acc && bus.mem_ack_i && w_owner_req;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:           w_next = bus.dm_req_i ? DM_ACC : bus.if_req_i ? IF_ACC : IDLE;
      IF_ACC, DM_ACC: w_next = bus.mem_ack_i ? RESP : r_state;
      default:        w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_state    <= IDLE;
      r_dm_own   <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_dm_own <= bus.dm_req_i;
        r_we     <= bus.dm_req_i & bus.dm_we_i;
        r_addr   <= bus.dm_req_i ? bus.dm_addr_i : bus.if_addr_i;
        r_wdata  <= bus.dm_req_i ? bus.dm_wdata_i : r_wdata;
      end
      if (w_cap && r_dm_own && !r_we) r_dm_rdata <= bus.mem_rdata_i;
      if (w_cap && !r_dm_own) r_if_rdata <= bus.mem_rdata_i;
    end
  end
  assign bus.mem_req_o   = w_acc;
  assign bus.mem_we_o    = r_we;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.if_rdata_o  = r_if_rdata;
  assign bus.dm_rdata_o  = r_dm_rdata;
  assign bus.if_ack_o    = (r_state == RESP) && !r_dm_own && bus.if_req_i;
  assign bus.dm_ack_o    = (r_state == RESP) && r_dm_own && bus.dm_req_i;
  assign bus.stall_o     = (bus.if_req_i && !bus.if_ack_o) || (bus.dm_req_i && !bus.dm_ack_o);
`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      if_wait_cnt_o <= '0;
      dm_wait_cnt_o <= '0;
    end else begin
      if (bus.if_req_i && !bus.if_ack_o && ~&if_wait_cnt_o) if_wait_cnt_o <= if_wait_cnt_o + 32'd1;
      if (bus.dm_req_i && !bus.dm_ack_o && ~&dm_wait_cnt_o) dm_wait_cnt_o <= dm_wait_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed and random scoreboard bench for unified_mem_arbiter.
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic start_n = 1'b0;
  always #5 clk = ~clk;
  unified_mem_arbiter_if bus ();
`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_wc, dm_wc;
`endif
  unified_mem_arbiter dut (
    .clk_i(clk),
    .start_i(start_n),
    .bus(bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .if_wait_cnt_o(if_wc),
    .dm_wait_cnt_o(dm_wc)
`endif
  );
  typedef struct {bit load; logic [31:0] d;} dm_t;
  int errors = 0, checks = 0, cyc = 0, mem_wait = 0, ack_cyc = -1, req_cycles = 0;
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] if_q[$];
  dm_t dm_q[$];
  logic [31:0] last_load = 0, last_if = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] init_val(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // memory model: fixed or random wait states, stores applied on completion
  initial begin
    bit busy;
    int wcnt;
    busy = 0;
    wcnt = 0;
    bus.mem_ack_i = 0;
    bus.mem_rdata_i = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!start_n) begin
        busy = 0;
        bus.mem_ack_i = 0;
      end else if (bus.mem_ack_i) begin
        bus.mem_ack_i = 0;
        bus.mem_rdata_i = $urandom;
      end else if (bus.mem_req_o) begin
        if (!busy) begin
          busy = 1;
          wcnt = mem_wait >= 0 ? mem_wait : int'($urandom_range(0, 3));
        end
        if (wcnt == 0) begin
          busy = 0;
          bus.mem_ack_i = 1;
          ack_cyc = cyc;
          bus.mem_rdata_i = mem_rd(bus.mem_addr_o);
          if (bus.mem_we_o) mem[bus.mem_addr_o] = bus.mem_wdata_o;
        end else wcnt--;
      end
    end
  end
  // monitor: pops the scoreboard on every ack, checks stall and request stability
  initial begin
    logic p_req, p_we;
    logic [31:0] p_addr, p_wdata;
    dm_t e;
    p_req = 0;
    forever begin
      @(negedge clk);
      if (start_n) begin
        if (bus.mem_req_o) req_cycles++;
        if (bus.if_ack_o) begin
          if (if_q.size() == 0) check("if_ack_unexpected", 1, 0);
          else check("if_rdata", bus.if_rdata_o, if_q.pop_front());
        end
        if (bus.dm_ack_o) begin
          if (dm_q.size() == 0) check("dm_ack_unexpected", 1, 0);
          else begin
            e = dm_q.pop_front();
            check(e.load ? "dm_rdata_load" : "dm_rdata_store", bus.dm_rdata_o, e.d);
          end
        end
        check("stall", bus.stall_o, (bus.if_req_i && !bus.if_ack_o) || (bus.dm_req_i && !bus.dm_ack_o));
        if (p_req && bus.mem_req_o) begin
          check("mem_addr_hold", bus.mem_addr_o, p_addr);
          check("mem_wdata_hold", bus.mem_wdata_o, p_wdata);
          check("mem_we_hold", bus.mem_we_o, p_we);
        end
      end
      p_req = bus.mem_req_o && start_n;
      p_we = bus.mem_we_o;
      p_addr = bus.mem_addr_o;
      p_wdata = bus.mem_wdata_o;
    end
  end
  task automatic wait_ack(input bit dm, output int at, output int waits);
    at = -1;
    waits = 0;
    for (int i = 0; i < 200 && at < 0; i++) begin
      @(negedge clk);
      if (dm ? bus.dm_ack_o : bus.if_ack_o) at = cyc;
      else waits++;
    end
    if (at < 0) check(dm ? "dm_ack_timeout" : "if_ack_timeout", 0, 1);
  endtask
  task automatic do_if(input logic [31:0] a, output int at, output int waits);
    bus.if_req_i = 1;
    bus.if_addr_i = a;
    last_if = ref_rd(a);
    if_q.push_back(last_if);
    wait_ack(0, at, waits);
    @(posedge clk);
    #1;
    bus.if_req_i = 0;
    bus.if_addr_i = $urandom;
  endtask
  task automatic do_dm(input bit we, input logic [31:0] a, input logic [31:0] wd, output int at, output int waits);
    bus.dm_req_i = 1;
    bus.dm_we_i = we;
    bus.dm_addr_i = a;
    bus.dm_wdata_i = wd;
    if (we) begin
      ref_mem[a] = wd;
      dm_q.push_back('{0, last_load});
    end else begin
      last_load = ref_rd(a);
      dm_q.push_back('{1, last_load});
    end
    wait_ack(1, at, waits);
    @(posedge clk);
    #1;
    bus.dm_req_i = 0;
    bus.dm_we_i = $urandom;
    bus.dm_addr_i = $urandom;
    bus.dm_wdata_i = $urandom;
  endtask
  initial begin
    int t0, ia, iw, da, dw, rc;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] ic0, dc0;
`endif
    bus.if_req_i = 0;
    bus.if_addr_i = 0;
    bus.dm_req_i = 0;
    bus.dm_we_i = 0;
    bus.dm_addr_i = 0;
    bus.dm_wdata_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", bus.mem_req_o, 0);
    check("rst_mem_we", bus.mem_we_o, 0);
    check("rst_acks", {bus.if_ack_o, bus.dm_ack_o}, 0);
    check("rst_mem_addr", bus.mem_addr_o, 0);
    check("rst_mem_wdata", bus.mem_wdata_o, 0);
    check("rst_rdata", bus.if_rdata_o | bus.dm_rdata_o, 0);
    @(posedge clk);
    #1 start_n = 1;
    // reset in the middle of a long fetch abandons it
    mem_wait = 20;
    bus.if_req_i = 1;
    bus.if_addr_i = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("acc_started", bus.mem_req_o, 1);
    start_n = 0;
    #1 check("async_rst_req", bus.mem_req_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_mem_req", bus.mem_req_o, 0);
    check("midrst_if_ack", bus.if_ack_o, 0);
    check("midrst_mem_addr", bus.mem_addr_o, 0);
    bus.if_req_i = 0;
    @(posedge clk);
    #1 start_n = 1;
    mem_wait = 0;
    @(posedge clk);
    #3 bus.mem_ack_i = 1;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_req", bus.mem_req_o, 0);
    end
    // single zero-wait fetch: ack in the third cycle
    mem[32'h10] = 32'h2009_0005;
    ref_mem[32'h10] = 32'h2009_0005;
    @(posedge clk);
    #1;
    t0 = cyc;
    rc = req_cycles;
    do_if(32'h10, ia, iw);
    check("fetch_latency", ia - t0, 2);
    check("fetch_req_cycles", req_cycles - rc, 1);
    // conflict: data first, then fetch
`ifdef ARB_PERF_CNT_EN
    ic0 = if_wc;
    dc0 = dm_wc;
`endif
    t0 = cyc;
    fork
      do_dm(0, 32'h20, 0, da, dw);
      do_if(32'h44, ia, iw);
    join
    check("conflict_dm_ack", da - t0, 2);
    check("conflict_if_ack", ia - t0, 5);
`ifdef ARB_PERF_CNT_EN
    check("perf_if_wait", if_wc - ic0, iw);
    check("perf_dm_wait", dm_wc - dc0, dw);
    check("perf_if_nonzero", iw != 0, 1);
`endif
    // store with four wait states
    mem_wait = 4;
    rc = req_cycles;
    do_dm(1, 32'h8, 32'hDEAD_BEEF, da, dw);
    check("store_ack_after_mem_ack", da, ack_cyc + 1);
    check("store_req_cycles", req_cycles - rc, 5);
    mem_wait = 0;
    do_dm(0, 32'h8, 0, da, dw);
    // flush: fetch dropped in its second access cycle
    mem_wait = 3;
    rc = req_cycles;
    bus.if_req_i = 1;
    bus.if_addr_i = 32'h30;
    for (int i = 0; i < 20 && !bus.mem_req_o; i++) @(negedge clk);
    @(posedge clk);
    #1 bus.if_req_i = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("flush_rdata_kept", bus.if_rdata_o, last_if);
    check("flush_req_cycles", req_cycles - rc, 4);
    // random traffic from both requesters
    mem_wait = -1;
    @(posedge clk);
    #1;
    fork
      repeat (40) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 do_if(32'($urandom_range(0, 63)) << 2, ia, iw);
      end
      repeat (40) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 do_dm(1'($urandom), 32'h100 + (32'($urandom_range(0, 15)) << 2), $urandom, da, dw);
      end
    join
    repeat (5) @(posedge clk);
    check("if_q_drained", if_q.size(), 0);
    check("dm_q_drained", dm_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
